// File: rtl/dm_hart_ctrl.sv
// dm_hart_ctrl: multi-hart run control for the debug module.
// Keeps the sticky per-hart halted/resumeack state and drives the per-hart
// debug requests. It also sequences one abstract command at a time on the
// captured hart: GO, EXEC, and then completion, exception or timeout.
module dm_hart_ctrl #(
  parameter int unsigned NrHarts    = 4,
  parameter int unsigned HartSelLen = 20,
  parameter int unsigned CmdTimeout = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dmactive_i,
  input  logic [HartSelLen-1:0] hartsel_i,
  input  logic                  haltreq_i,
  input  logic                  resumereq_i,
  input  logic                  cmd_valid_i,
  input  logic                  unsupported_cmd_i,
  input  logic [NrHarts-1:0]    halted_i,
  input  logic [NrHarts-1:0]    resuming_i,
  input  logic                  going_i,
  input  logic                  exception_i,
  output logic [NrHarts-1:0]    debug_req_o,
  output logic                  go_o,
  output logic                  resume_o,
  output logic [HartSelLen-1:0] cmd_hart_o,
  output logic                  cmdbusy_o,
  output logic                  cmderror_valid_o,
  output logic [2:0]            cmderror_o,
  output logic [NrHarts-1:0]    halted_o,
  output logic [NrHarts-1:0]    resumeack_o,
  output logic                  anyhalted_o,
  output logic                  allhalted_o
);

  // Abstract command error codes.
  localparam logic [2:0] ErrNone         = 3'd0;
  localparam logic [2:0] ErrNotSupported = 3'd2;
  localparam logic [2:0] ErrException    = 3'd3;
  localparam logic [2:0] ErrHaltResume   = 3'd4;
  localparam logic [2:0] ErrOther        = 3'd7;

  // Hart indices are compared in a width that holds both hartsel and NrHarts
  // (NrHarts <= 1024 needs 11 bits), so neither side truncates.
  localparam int unsigned ExtW = HartSelLen + 11;

  // Last counter value before the command is abandoned; unused when the
  // timeout is disabled.
  localparam logic [31:0] TimeoutLast = (CmdTimeout == 0) ? 32'd0 : 32'(CmdTimeout - 1);

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Go   = 2'd1,
    Exec = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [31:0]             cnt_q, cnt_d;
  logic                    go_q, go_d;
  logic                    resume_q, resume_d;
  logic [HartSelLen-1:0]   cmd_hart_q, cmd_hart_d;
  logic                    cmdbusy_q, cmdbusy_d;
  logic                    err_valid_q, err_valid_d;
  logic [2:0]              err_q, err_d;
  logic [NrHarts-1:0]      halted_q, halted_d;
  logic [NrHarts-1:0]      resumeack_q, resumeack_d;
  logic [NrHarts-1:0]      debug_req_q, debug_req_d;
  logic                    resumereq_q, resumereq_d;
  logic                    anyhalted_q, anyhalted_d;
  logic                    allhalted_q, allhalted_d;

  logic                    sel_valid;
  logic [NrHarts-1:0]      sel_onehot;
  logic [NrHarts-1:0]      cmd_onehot;
  logic                    sel_halted;
  logic                    resume_start;
  logic                    timeout_hit;

  // Decode the current selection and the captured command hart into one-hot masks.
  always_comb begin
    sel_valid  = (ExtW'(hartsel_i) < ExtW'(NrHarts));
    sel_onehot = '0;
    cmd_onehot = '0;
    for (int unsigned h = 0; h < NrHarts; h++) begin
      sel_onehot[h] = (ExtW'(hartsel_i) == ExtW'(h));
      cmd_onehot[h] = (ExtW'(cmd_hart_q) == ExtW'(h));
    end
    sel_halted   = sel_valid && (|(halted_q & sel_onehot));
    // Only a fresh resume request on a halted hart with no command running starts a resume.
    resume_start = resumereq_i && !resumereq_q && sel_halted && !cmdbusy_q;
  end

  // Per-hart halted / resumeack / debug request state and the resume flag.
  always_comb begin
    // A halted strobe beats a simultaneous resuming strobe on the same hart.
    halted_d    = (halted_q & ~resuming_i) | halted_i;
    debug_req_d = haltreq_i ? sel_onehot : '0;
    resumereq_d = resumereq_i;
    resume_d    = resume_q;
    resumeack_d = resumeack_q;
    if (|(resuming_i & sel_onehot)) begin
      resume_d    = 1'b0;
      resumeack_d = resumeack_q | (resuming_i & sel_onehot);
    end
    if (resume_start) begin
      resume_d    = 1'b1;
      resumeack_d = resumeack_d & ~sel_onehot;
    end
    anyhalted_d = |halted_d;
    allhalted_d = &halted_d;
  end

  // Command sequencer next state: IDLE -> GO -> EXEC -> IDLE, with the timeout
  // taking priority over every other event once the budget is spent.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    go_d        = go_q;
    cmdbusy_d   = cmdbusy_q;
    cmd_hart_d  = cmd_hart_q;
    err_valid_d = 1'b0;
    err_d       = ErrNone;
    timeout_hit = (CmdTimeout != 0) && (state_q != Idle) && (cnt_q == TimeoutLast);

    if ((CmdTimeout != 0) && (state_q != Idle)) begin
      cnt_d = cnt_q + 32'd1;
    end

    if (timeout_hit) begin
      state_d     = Idle;
      cnt_d       = '0;
      go_d        = 1'b0;
      cmdbusy_d   = 1'b0;
      err_valid_d = 1'b1;
      err_d       = ErrOther;
    end else begin
      case (state_q)
        Idle: begin
          if (cmd_valid_i) begin
            if (unsupported_cmd_i) begin
              err_valid_d = 1'b1;
              err_d       = ErrNotSupported;
            end else if (!sel_halted) begin
              err_valid_d = 1'b1;
              err_d       = ErrHaltResume;
            end else begin
              state_d    = Go;
              cnt_d      = '0;
              go_d       = 1'b1;
              cmdbusy_d  = 1'b1;
              cmd_hart_d = hartsel_i;
            end
          end
        end
        Go: begin
          if (going_i) begin
            state_d = Exec;
            go_d    = 1'b0;
          end
        end
        Exec: begin
          // An exception wins over a simultaneous halted strobe.
          if (exception_i) begin
            state_d     = Idle;
            cmdbusy_d   = 1'b0;
            err_valid_d = 1'b1;
            err_d       = ErrException;
          end else if (|(halted_i & cmd_onehot)) begin
            state_d   = Idle;
            cmdbusy_d = 1'b0;
          end
        end
        default: begin
          state_d   = Idle;
          go_d      = 1'b0;
          cmdbusy_d = 1'b0;
        end
      endcase
    end
  end

  // All state registers; an inactive debug module clears exactly like reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || !dmactive_i) begin
      state_q     <= Idle;
      cnt_q       <= '0;
      go_q        <= 1'b0;
      resume_q    <= 1'b0;
      cmd_hart_q  <= '0;
      cmdbusy_q   <= 1'b0;
      err_valid_q <= 1'b0;
      err_q       <= ErrNone;
      halted_q    <= '0;
      resumeack_q <= '1;
      debug_req_q <= '0;
      resumereq_q <= 1'b0;
      anyhalted_q <= 1'b0;
      allhalted_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      go_q        <= go_d;
      resume_q    <= resume_d;
      cmd_hart_q  <= cmd_hart_d;
      cmdbusy_q   <= cmdbusy_d;
      err_valid_q <= err_valid_d;
      err_q       <= err_d;
      halted_q    <= halted_d;
      resumeack_q <= resumeack_d;
      debug_req_q <= debug_req_d;
      resumereq_q <= resumereq_d;
      anyhalted_q <= anyhalted_d;
      allhalted_q <= allhalted_d;
    end
  end

  assign debug_req_o      = debug_req_q;
  assign go_o             = go_q;
  assign resume_o         = resume_q;
  assign cmd_hart_o       = cmd_hart_q;
  assign cmdbusy_o        = cmdbusy_q;
  assign cmderror_valid_o = err_valid_q;
  assign cmderror_o       = err_q;
  assign halted_o         = halted_q;
  assign resumeack_o      = resumeack_q;
  assign anyhalted_o      = anyhalted_q;
  assign allhalted_o      = allhalted_q;

endmodule

// File: tb/tb_dm_hart_ctrl.sv
// tb_dm_hart_ctrl: directed scenarios plus randomized traffic, with every
// output compared each cycle against a cycle-count based behavioural model.
module tb_dm_hart_ctrl;

  localparam int unsigned NH  = 4;
  localparam int unsigned HSL = 20;
  localparam int unsigned TO  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_ni, dmactive_i, haltreq_i, resumereq_i, cmd_valid_i;
  logic            unsupported_cmd_i, going_i, exception_i;
  logic [HSL-1:0]  hartsel_i;
  logic [NH-1:0]   halted_i, resuming_i;
  logic [NH-1:0]   debug_req_o, halted_o, resumeack_o;
  logic            go_o, resume_o, cmdbusy_o, cmderror_valid_o, anyhalted_o, allhalted_o;
  logic [HSL-1:0]  cmd_hart_o;
  logic [2:0]      cmderror_o;

  dm_hart_ctrl #(.NrHarts(NH), .HartSelLen(HSL), .CmdTimeout(TO)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .dmactive_i(dmactive_i), .hartsel_i(hartsel_i),
    .haltreq_i(haltreq_i), .resumereq_i(resumereq_i), .cmd_valid_i(cmd_valid_i),
    .unsupported_cmd_i(unsupported_cmd_i), .halted_i(halted_i), .resuming_i(resuming_i),
    .going_i(going_i), .exception_i(exception_i), .debug_req_o(debug_req_o), .go_o(go_o),
    .resume_o(resume_o), .cmd_hart_o(cmd_hart_o), .cmdbusy_o(cmdbusy_o),
    .cmderror_valid_o(cmderror_valid_o), .cmderror_o(cmderror_o), .halted_o(halted_o),
    .resumeack_o(resumeack_o), .anyhalted_o(anyhalted_o), .allhalted_o(allhalted_o)
  );

  // Behavioural model: command progress is "in flight", "go still pending" and
  // the edge number at which it started; the timeout is an edge-count distance.
  logic [NH-1:0] m_halted, m_ack, m_dreq;
  logic          m_go, m_resume, m_busy, m_errv, m_prev;
  logic [2:0]    m_err;
  int unsigned   m_cmd_hart, cyc, start_cyc;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
  endtask

  task automatic model_update();
    int unsigned s;
    bit sel_ok;
    logic [NH-1:0] old_halted;
    if (!rst_ni || !dmactive_i) begin
      m_halted = '0; m_ack = '1; m_dreq = '0; m_go = 0; m_resume = 0; m_busy = 0;
      m_errv = 0; m_err = 0; m_prev = 0; m_cmd_hart = 0;
    end else begin
      s = int'(hartsel_i);
      sel_ok = (s < NH);
      old_halted = m_halted;
      m_errv = 0; m_err = 0;
      for (int h = 0; h < NH; h++) begin
        if (halted_i[h]) m_halted[h] = 1'b1;
        else if (resuming_i[h]) m_halted[h] = 1'b0;
      end
      m_dreq = '0;
      if (haltreq_i && sel_ok) m_dreq[s] = 1'b1;
      if (sel_ok && resuming_i[s]) begin
        m_resume = 0;
        m_ack[s] = 1'b1;
      end
      if (resumereq_i && !m_prev && sel_ok && old_halted[s] && !m_busy) begin
        m_resume = 1;
        m_ack[s] = 1'b0;
      end
      m_prev = resumereq_i;
      if (!m_busy) begin
        if (cmd_valid_i) begin
          if (unsupported_cmd_i) begin m_errv = 1; m_err = 3'd2; end
          else if (!sel_ok || !old_halted[s]) begin m_errv = 1; m_err = 3'd4; end
          else begin
            m_busy = 1; m_go = 1; m_cmd_hart = s; start_cyc = cyc;
          end
        end
      end else if (cyc - start_cyc == TO) begin
        m_errv = 1; m_err = 3'd7; m_busy = 0; m_go = 0;
      end else if (m_go) begin
        if (going_i) m_go = 0;
      end else begin
        if (exception_i) begin m_errv = 1; m_err = 3'd3; m_busy = 0; end
        else if (halted_i[m_cmd_hart]) m_busy = 0;
      end
    end
    cyc++;
  endtask

  task automatic compare_all();
    check("debug_req", 32'(debug_req_o), 32'(m_dreq));
    check("go", 32'(go_o), 32'(m_go));
    check("resume", 32'(resume_o), 32'(m_resume));
    check("cmd_hart", 32'(cmd_hart_o), 32'(m_cmd_hart));
    check("cmdbusy", 32'(cmdbusy_o), 32'(m_busy));
    check("err_valid", 32'(cmderror_valid_o), 32'(m_errv));
    check("err_code", 32'(cmderror_o), 32'(m_err));
    check("halted", 32'(halted_o), 32'(m_halted));
    check("resumeack", 32'(resumeack_o), 32'(m_ack));
    check("anyhalted", 32'(anyhalted_o), 32'(|m_halted));
    check("allhalted", 32'(allhalted_o), 32'(&m_halted));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    rst_ni = 1; dmactive_i = 1; hartsel_i = '0; haltreq_i = 0; resumereq_i = 0;
    cmd_valid_i = 0; unsupported_cmd_i = 0; halted_i = '0; resuming_i = '0;
    going_i = 0; exception_i = 0;
  endtask

  task automatic random_inputs();
    int unsigned r;
    rst_ni     = ($urandom_range(0, 299) != 0);
    dmactive_i = ($urandom_range(0, 199) != 0);
    r = $urandom_range(0, 9);
    if (r < 8) hartsel_i = HSL'($urandom_range(0, 3));
    else if (r == 8) hartsel_i = HSL'($urandom_range(4, 7));
    else hartsel_i = HSL'($urandom);
    haltreq_i = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 3) == 0) resumereq_i = ~resumereq_i;
    cmd_valid_i       = ($urandom_range(0, 5) == 0);
    unsupported_cmd_i = ($urandom_range(0, 4) == 0);
    for (int h = 0; h < NH; h++) begin
      halted_i[h]   = ($urandom_range(0, 9) == 0);
      resuming_i[h] = ($urandom_range(0, 9) == 0);
    end
    going_i     = ($urandom_range(0, 2) == 0);
    exception_i = ($urandom_range(0, 11) == 0);
  endtask

  initial begin
    cyc = 0; start_cyc = 0;
    m_halted = '0; m_ack = '1; m_dreq = '0; m_go = 0; m_resume = 0; m_busy = 0;
    m_errv = 0; m_err = 0; m_prev = 0; m_cmd_hart = 0;
    idle_inputs();

    // Reset held two cycles with other inputs toggling.
    random_inputs(); rst_ni = 0; step();
    random_inputs(); rst_ni = 0; step();
    check("rst_go", 32'(go_o), 32'd0);
    check("rst_busy", 32'(cmdbusy_o), 32'd0);
    check("rst_dreq", 32'(debug_req_o), 32'd0);
    check("rst_halted", 32'(halted_o), 32'd0);
    check("rst_ack", 32'(resumeack_o), 32'hF);
    check("rst_err", 32'({cmderror_valid_o, cmderror_o}), 32'd0);

    // Halt hart 2.
    idle_inputs(); step();
    hartsel_i = 2; haltreq_i = 1; step();
    check("halt_dreq", 32'(debug_req_o), 32'h4);
    haltreq_i = 0; halted_i = 4'b0100; step();
    check("halt_halted", 32'(halted_o), 32'h4);
    check("halt_model", 32'(m_halted), 32'h4);
    check("halt_any_all", 32'({anyhalted_o, allhalted_o}), 32'h2);

    // Successful command on hart 2, hartsel moved away mid-command.
    halted_i = '0; cmd_valid_i = 1; step();
    check("cmd_go_busy", 32'({go_o, cmdbusy_o}), 32'h3);
    check("cmd_hart", 32'(cmd_hart_o), 32'd2);
    cmd_valid_i = 0; hartsel_i = 0; going_i = 1; step();
    check("cmd_go_clr", 32'({go_o, cmdbusy_o}), 32'h1);
    going_i = 0; halted_i = 4'b0100; step();
    check("cmd_done", 32'({cmdbusy_o, cmderror_valid_o}), 32'h0);
    halted_i = '0;

    // Unsupported command.
    hartsel_i = 2; cmd_valid_i = 1; unsupported_cmd_i = 1; step();
    check("err_unsup", 32'({cmderror_valid_o, cmderror_o}), 32'hA);
    cmd_valid_i = 0; unsupported_cmd_i = 0; step();
    check("err_pulse_end", 32'({cmderror_valid_o, cmderror_o}), 32'h0);

    // Hart 1 not halted.
    hartsel_i = 1; cmd_valid_i = 1; step();
    check("err_halt", 32'({cmderror_valid_o, cmderror_o}), 32'hC);
    check("err_halt_model", 32'(m_err), 32'd4);

    // Exception and halted together in EXEC.
    hartsel_i = 2; step();
    cmd_valid_i = 0; going_i = 1; step();
    going_i = 0; exception_i = 1; halted_i = 4'b0100; step();
    check("err_exc", 32'({cmderror_valid_o, cmderror_o}), 32'hB);
    check("exc_halted", 32'(halted_o[2]), 32'd1);
    check("exc_busy", 32'(cmdbusy_o), 32'd0);
    exception_i = 0; halted_i = '0;

    // Timeout: no going strobe.
    cmd_valid_i = 1; step();
    cmd_valid_i = 0;
    for (int i = 0; i < 7; i++) step();
    check("to_still_busy", 32'(cmdbusy_o), 32'd1);
    step();
    check("err_timeout", 32'({cmderror_valid_o, cmderror_o}), 32'hF);
    check("to_go_busy", 32'({go_o, cmdbusy_o}), 32'h0);
    step();

    // Resume hart 2, then an ignored edge on a nonexistent hart.
    resumereq_i = 1; step();
    check("res_flag", 32'(resume_o), 32'd1);
    check("res_ack_clr", 32'(resumeack_o), 32'hB);
    resuming_i = 4'b0100; step();
    check("res_done", 32'(resume_o), 32'd0);
    check("res_ack_set", 32'(resumeack_o), 32'hF);
    check("res_halted", 32'(halted_o), 32'h0);
    resuming_i = '0; resumereq_i = 0; halted_i = 4'b0001; step();
    halted_i = '0; hartsel_i = 7; resumereq_i = 1; haltreq_i = 1; step();
    check("res_bad_sel", 32'({resume_o, resumeack_o}), 32'hF);
    check("dreq_bad_sel", 32'(debug_req_o), 32'h0);
    resumereq_i = 0; haltreq_i = 0; step();

    // dmactive low clears like reset.
    dmactive_i = 0; step();
    check("dmact_clear", 32'({halted_o, resumeack_o}), 32'h0F);
    idle_inputs(); step();

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      random_inputs();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
